// File: rtl/id_ex_stage_reg_pkg.sv
// Shared ALU encodings: ALU Signal codes, ALUOp codes and R-type funct codes.
// Used by the ID/EX register, its ALU-control decoder and the EX-stage ALU.
package id_ex_stage_reg_pkg;

  localparam logic [2:0] SIG_AND = 3'b000;
  localparam logic [2:0] SIG_OR  = 3'b001;
  localparam logic [2:0] SIG_ADD = 3'b010;
  localparam logic [2:0] SIG_SUB = 3'b110;
  localparam logic [2:0] SIG_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/id_ex_stage_reg_alu_ctrl.sv
// Combinational ALU-control decoder: ALUOp and funct to the 3-bit ALU Signal.
// An R-type instruction with an unknown funct falls back to ADD and raises illegal.
module alu_ctrl
  import id_ex_stage_reg_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] signal,
  output logic       illegal
);

  always_comb begin
    signal  = SIG_ADD;
    illegal = 1'b0;
    unique case (alu_op)
      ALUOP_ADD: signal = SIG_ADD;
      ALUOP_SUB: signal = SIG_SUB;
      ALUOP_ORI: signal = SIG_OR;
      default: begin
        case (funct)
          FUNCT_ADD: signal = SIG_ADD;
          FUNCT_SUB: signal = SIG_SUB;
          FUNCT_AND: signal = SIG_AND;
          FUNCT_OR:  signal = SIG_OR;
          FUNCT_SLT: signal = SIG_SLT;
          default: begin
            signal  = SIG_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands and control for the EX-stage ALU,
// with stall (hold) and flush (bubble) from the hazard unit. Priority: rst > flush > stall > load.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [WIDTH-1:0]    id_rs_data,
  input  logic [WIDTH-1:0]    id_rt_data,
  input  logic [15:0]         id_imm16,
  input  logic [5:0]          id_funct,
  input  logic [REG_ADDR-1:0] id_rt,
  input  logic [REG_ADDR-1:0] id_rd,
  input  logic [1:0]          id_alu_op,
  input  logic                id_alu_src,
  input  logic                id_reg_dst,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  output logic                ex_valid,
  output logic [WIDTH-1:0]    ex_a,
  output logic [WIDTH-1:0]    ex_b,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic [2:0]          ex_signal,
  output logic [REG_ADDR-1:0] ex_dest,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_illegal
);

  logic [2:0]          sig;
  logic                illegal;
  logic [WIDTH-1:0]    ext_imm;

  logic                valid_d, valid_q;
  logic [WIDTH-1:0]    a_d, a_q, b_d, b_q, sd_d, sd_q;
  logic [2:0]          sig_d, sig_q;
  logic [REG_ADDR-1:0] dest_d, dest_q;
  logic                rw_d, rw_q, mr_d, mr_q, mw_d, mw_q, m2r_d, m2r_q, ill_d, ill_q;

  alu_ctrl u_alu_ctrl (
    .alu_op  (id_alu_op),
    .funct   (id_funct),
    .signal  (sig),
    .illegal (illegal)
  );

  // ORI is a logical op, so its immediate is zero-extended; everything else sign-extends.
  assign ext_imm = (id_alu_op == ALUOP_ORI)
                 ? {{(WIDTH-16){1'b0}}, id_imm16}
                 : {{(WIDTH-16){id_imm16[15]}}, id_imm16};

  always_comb begin
    valid_d = 1'b0;
    a_d     = '0;
    b_d     = '0;
    sd_d    = '0;
    sig_d   = SIG_AND;
    dest_d  = '0;
    rw_d    = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    m2r_d   = 1'b0;
    ill_d   = 1'b0;
    if (id_valid) begin
      valid_d = 1'b1;
      a_d     = id_rs_data;
      b_d     = id_alu_src ? ext_imm : id_rt_data;
      sd_d    = id_rt_data;
      sig_d   = sig;
      dest_d  = id_reg_dst ? id_rd : id_rt;
      rw_d    = id_reg_write & ~illegal;
      mr_d    = id_mem_read;
      mw_d    = id_mem_write;
      m2r_d   = id_mem_to_reg;
      ill_d   = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sd_q    <= '0;
      sig_q   <= SIG_AND;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (!stall) begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sd_q    <= sd_d;
      sig_q   <= sig_d;
      dest_q  <= dest_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      m2r_q   <= m2r_d;
      ill_q   <= ill_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_a          = a_q;
  assign ex_b          = b_q;
  assign ex_store_data = sd_q;
  assign ex_signal     = sig_q;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = rw_q;
  assign ex_mem_read   = mr_q;
  assign ex_mem_write  = mw_q;
  assign ex_mem_to_reg = m2r_q;
  assign ex_illegal    = ill_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: a reference model predicts each cycle's outputs,
// the prediction is queued when stimulus is driven and compared after the clock edge.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm16;
  logic [5:0]  id_funct;
  logic [4:0]  id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_signal;
  logic [4:0]  ex_dest;

  typedef struct packed {
    logic        valid;
    logic [31:0] a, b, sd;
    logic [2:0]  sig;
    logic [4:0]  dest;
    logic        rw, mr, mw, m2r, ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t model_q = '0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
    .id_funct(id_funct), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_signal(ex_signal), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_illegal(ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input exp_t prev);
    exp_t e;
    logic [31:0] ext;
    e = '0;
    if (rst || flush) return '0;
    if (stall) return prev;
    if (!id_valid) return '0;
    ext = (id_alu_op == 2'b11) ? {16'h0000, id_imm16} : {{16{id_imm16[15]}}, id_imm16};
    e.valid = 1'b1;
    e.a     = id_rs_data;
    e.b     = id_alu_src ? ext : id_rt_data;
    e.sd    = id_rt_data;
    e.dest  = id_reg_dst ? id_rd : id_rt;
    e.mr    = id_mem_read;
    e.mw    = id_mem_write;
    e.m2r   = id_mem_to_reg;
    case (id_alu_op)
      2'b00: e.sig = 3'b010;
      2'b01: e.sig = 3'b110;
      2'b11: e.sig = 3'b001;
      default:
        case (id_funct)
          6'b100000: e.sig = 3'b010;
          6'b100010: e.sig = 3'b110;
          6'b100100: e.sig = 3'b000;
          6'b100101: e.sig = 3'b001;
          6'b101010: e.sig = 3'b111;
          default: begin e.sig = 3'b010; e.ill = 1'b1; end
        endcase
    endcase
    e.rw = id_reg_write & ~e.ill;
    return e;
  endfunction

  task automatic randomize_inputs();
    id_valid      = 1'b1;
    id_rs_data    = $urandom;
    id_rt_data    = $urandom;
    id_imm16      = 16'($urandom);
    id_funct      = 6'($urandom);
    id_rt         = 5'($urandom);
    id_rd         = 5'($urandom);
    id_alu_op     = 2'($urandom);
    id_alu_src    = 1'($urandom);
    id_reg_dst    = 1'($urandom);
    id_reg_write  = 1'($urandom);
    id_mem_read   = 1'($urandom);
    id_mem_write  = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
  endtask

  // Queue the prediction, clock once, then pop and compare every output.
  task automatic step();
    exp_t e;
    model_q = predict(model_q);
    sb_q.push_back(model_q);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("valid", 32'(ex_valid), 32'(e.valid));
    chk("a", ex_a, e.a);
    chk("b", ex_b, e.b);
    chk("store_data", ex_store_data, e.sd);
    chk("signal", 32'(ex_signal), 32'(e.sig));
    chk("dest", 32'(ex_dest), 32'(e.dest));
    chk("reg_write", 32'(ex_reg_write), 32'(e.rw));
    chk("mem_read", 32'(ex_mem_read), 32'(e.mr));
    chk("mem_write", 32'(ex_mem_write), 32'(e.mw));
    chk("mem_to_reg", 32'(ex_mem_to_reg), 32'(e.m2r));
    chk("illegal", 32'(ex_illegal), 32'(e.ill));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_a"}, ex_a, 32'd0);
    chk({tag, "_b"}, ex_b, 32'd0);
    chk({tag, "_signal"}, 32'(ex_signal), 32'd0);
    chk({tag, "_dest"}, 32'(ex_dest), 32'd0);
    chk({tag, "_ctl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
  endtask

  initial begin
    logic [31:0] a_rs;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    randomize_inputs();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      stall = 1'($urandom);
      flush = 1'($urandom);
      step();
      chk_bubble("reset");
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    // R-type SUB
    randomize_inputs();
    id_alu_op = 2'b10; id_funct = 6'b100010; id_rs_data = 32'd5; id_rt_data = 32'd3;
    id_alu_src = 1'b0; id_reg_dst = 1'b1; id_rd = 5'd9; id_reg_write = 1'b1;
    step();
    chk("sub_signal", 32'(ex_signal), 32'h6);
    chk("sub_a", ex_a, 32'd5);
    chk("sub_b", ex_b, 32'd3);
    chk("sub_dest", 32'(ex_dest), 32'd9);
    chk("sub_rw", 32'(ex_reg_write), 32'd1);

    // addi with negative immediate
    randomize_inputs();
    id_alu_op = 2'b00; id_imm16 = 16'hFFFC; id_alu_src = 1'b1; id_reg_dst = 1'b0; id_rt = 5'd17;
    step();
    chk("addi_b", ex_b, 32'hFFFF_FFFC);
    chk("addi_signal", 32'(ex_signal), 32'h2);
    chk("addi_dest", 32'(ex_dest), 32'd17);

    // ori zero-extends
    randomize_inputs();
    id_alu_op = 2'b11; id_imm16 = 16'h8001; id_alu_src = 1'b1;
    step();
    chk("ori_b", ex_b, 32'h0000_8001);
    chk("ori_signal", 32'(ex_signal), 32'h1);

    // Stall holds A while B is presented
    randomize_inputs();
    a_rs = id_rs_data;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      step();
      chk("stall_hold_a", ex_a, a_rs);
    end
    stall = 1'b0;
    step();
    chk("stall_release_b", ex_a, id_rs_data);

    // Stall and flush together insert a bubble
    randomize_inputs();
    stall = 1'b1; flush = 1'b1;
    step();
    chk_bubble("stall_flush");
    stall = 1'b0; flush = 1'b0;

    // Unsupported funct
    randomize_inputs();
    id_alu_op = 2'b10; id_funct = 6'h3F; id_reg_write = 1'b1;
    step();
    chk("illegal_flag", 32'(ex_illegal), 32'd1);
    chk("illegal_rw", 32'(ex_reg_write), 32'd0);
    chk("illegal_signal", 32'(ex_signal), 32'h2);

    // Reset arriving mid-stall clears at once
    randomize_inputs();
    step();
    stall = 1'b1; rst = 1'b1;
    step();
    chk_bubble("rst_in_stall");
    rst = 1'b0; stall = 1'b0;

    // Random mix of valid, stall, flush, reset
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      id_valid = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) id_alu_op = 2'b10;
      if ($urandom_range(0, 1) == 1) id_funct = 6'b100000 | 6'(2 * $urandom_range(0, 5));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
